// File: rtl/radix5_fft_seq.sv
// Address/strobe sequencer for an in-place radix-5 DIF FFT over one NPTS-point RAM.
// Optional macro RADIX5_TWIDDLE_IDX_EN adds the tw_idx output (twiddle exponents
// aligned with wr_addr); the default build omits the port and its logic.
module radix5_fft_seq #(
  parameter int ADDR_W = 5,
  parameter int STAGES = 2,
  parameter int NPTS   = 25,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [5*ADDR_W-1:0] rd_addr,
  output logic                bfly_in_vld,
  output logic                wr_en,
  output logic [5*ADDR_W-1:0] wr_addr,
  output logic [2:0]          stage
`ifdef RADIX5_TWIDDLE_IDX_EN
  ,
  output logic [5*ADDR_W-1:0] tw_idx
`endif
);

  localparam int DLY = RD_LAT + BF_LAT;
  localparam int NBF = NPTS / 5;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic                issue, load_first, load_next, inflight;
  logic [2:0]          stage_new;
  logic [ADDR_W-1:0]   off, base, stride, bf_cnt;
  logic [5*ADDR_W-1:0] cur_flat, last_addr;
  logic                vld_line  [DLY];
  logic [5*ADDR_W-1:0] addr_line [DLY];

  // 5^e with constant multiplies only; used for stride and twiddle step per stage
  function automatic logic [ADDR_W-1:0] pow5(input int e);
    int p;
    p = 1;
    for (int i = 0; i < STAGES; i++)
      if (i < e) p = p * 5;
    return p[ADDR_W-1:0];
  endfunction

  // Register the FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and control strobes
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    load_first = 1'b0;
    load_next  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_first = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        busy  = 1'b1;
        issue = !hold;
        if (issue && bf_cnt == ADDR_W'(NBF - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // The final write may still be on the last tap; nothing earlier may be
        if (!inflight) begin
          if (stage == 3'(STAGES - 1)) begin
            state_nxt = DONE;
          end else begin
            load_next = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en     = issue;
  assign stage_new = load_first ? 3'd0 : stage + 3'd1;

  // Any valid bit in flight short of the write tap
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < DLY - 1; i++) inflight = inflight | vld_line[i];
  end

  // Butterfly counters: off steps first, base accumulates without multiplies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage  <= '0;
      stride <= '0;
      off    <= '0;
      base   <= '0;
      bf_cnt <= '0;
    end else if (load_first || load_next) begin
      stage  <= stage_new;
      stride <= pow5(STAGES - 1 - int'(stage_new));
      off    <= '0;
      base   <= '0;
      bf_cnt <= '0;
    end else if (issue) begin
      bf_cnt <= bf_cnt + ADDR_W'(1);
      if (off == stride - ADDR_W'(1)) begin
        off  <= '0;
        base <= base + (stride << 2) + ADDR_W'(1);
      end else begin
        off  <= off + ADDR_W'(1);
        base <= base + ADDR_W'(1);
      end
    end
  end

  // Element addresses base + m*S built by repeated addition
  always_comb begin
    logic [ADDR_W-1:0] a;
    a = base;
    for (int m = 0; m < 5; m++) begin
      cur_flat[m*ADDR_W +: ADDR_W] = a;
      a = a + stride;
    end
  end

  // Remember the last issued addresses so rd_addr holds while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_addr <= '0;
    else if (issue) last_addr <= cur_flat;
  end

  assign rd_addr = issue ? cur_flat : last_addr;

  // Read-latency plus butterfly-latency delay line for valid and addresses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) begin
        vld_line[i]  <= 1'b0;
        addr_line[i] <= '0;
      end
    end else begin
      vld_line[0]  <= issue;
      addr_line[0] <= cur_flat;
      for (int i = 1; i < DLY; i++) begin
        vld_line[i]  <= vld_line[i-1];
        addr_line[i] <= addr_line[i-1];
      end
    end
  end

  assign bfly_in_vld = vld_line[RD_LAT-1];
  assign wr_en       = vld_line[DLY-1];
  assign wr_addr     = addr_line[DLY-1];

`ifdef RADIX5_TWIDDLE_IDX_EN
  logic [ADDR_W-1:0]   tw_t, tw_step;
  logic [5*ADDR_W-1:0] tw_flat;
  logic [5*ADDR_W-1:0] tw_line [DLY];

  // (a + b) mod NPTS for operands already below NPTS
  function automatic logic [ADDR_W-1:0] add_mod(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (ADDR_W+1)'(NPTS)) sum = sum - (ADDR_W+1)'(NPTS);
    return sum[ADDR_W-1:0];
  endfunction

  // Track off*5^s alongside off; it never reaches NPTS so no wrap is needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_t    <= '0;
      tw_step <= '0;
    end else if (load_first || load_next) begin
      tw_t    <= '0;
      tw_step <= pow5(int'(stage_new));
    end else if (issue) begin
      if (off == stride - ADDR_W'(1)) tw_t <= '0;
      else                            tw_t <= tw_t + tw_step;
    end
  end

  // Element m exponent m*tw_t mod NPTS by modular accumulation
  always_comb begin
    logic [ADDR_W-1:0] t;
    t = '0;
    for (int m = 0; m < 5; m++) begin
      tw_flat[m*ADDR_W +: ADDR_W] = t;
      t = add_mod(t, tw_t);
    end
  end

  // Carry twiddle exponents down the same delay line as the addresses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) tw_line[i] <= '0;
    end else begin
      tw_line[0] <= tw_flat;
      for (int i = 1; i < DLY; i++) tw_line[i] <= tw_line[i-1];
    end
  end

  assign tw_idx = tw_line[DLY-1];
`endif

endmodule

// File: doc/radix5_fft_seq.md
Name: radix5_fft_seq

Overview:
- Sequencer for one shared radix-5 butterfly datapath, run in place over a single NPTS-point complex sample RAM.
- Generates the 5-point read addresses for every butterfly of every decimation-in-frequency stage and tracks data through RAM read latency plus butterfly latency.
- Generates in-place write-back addresses and strobes, waits for the pipeline to drain between stages, and signals completion.
- Sits between the top-level FFT control and the butterfly/RAM pair; it carries addresses and strobes only, no sample data.

Parameters:
- ADDR_W, 5, sample-RAM address width.
- STAGES, 2, number of radix-5 stages.
- NPTS, 25, points per transform; must equal 5^STAGES.
- RD_LAT, 1, RAM read latency in cycles (rd_en to data valid).
- BF_LAT, 12, butterfly latency in cycles (bfly_in_vld to outputs valid).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to run a full transform.
- hold, input, 1, stall request; pauses butterfly issue.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse after the final write.
- rd_en, output, 1, read strobe for the 5 addresses on rd_addr.
- rd_addr, output, 5*ADDR_W, element m of the butterfly at bits [m*ADDR_W +: ADDR_W].
- bfly_in_vld, output, 1, butterfly input valid; rd_en delayed by RD_LAT.
- wr_en, output, 1, write-back strobe; bfly_in_vld delayed by BF_LAT.
- wr_addr, output, 5*ADDR_W, rd_addr delayed by RD_LAT+BF_LAT (in-place).
- stage, output, 3, index of the stage currently issuing.

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; every delay-line valid bit and all counters cleared.
- Reset mid-transform aborts with no further wr_en.
- States:
  - IDLE: start=1 moves to ISSUE with stage=0; busy rises next cycle.
  - ISSUE: each cycle with hold=0 issues one butterfly (rd_en=1) and advances the counters. With hold=1, rd_en=0 and the counters freeze. After NPTS/5 butterflies go to DRAIN.
  - DRAIN: no issue; wait until no valid bit is in flight (last wr_en seen). Then go to ISSUE with stage+1, or to DONE if stage==STAGES-1. hold is ignored.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- start outside IDLE is ignored.
- Address generation for stage s:
  - Stride S = 5^(STAGES-1-s).
  - Counters off (0..S-1) and grp (0..NPTS/(5S)-1); off increments first, wrapping to 0 and incrementing grp.
  - Base = grp*5*S + off; element m address = base + m*S.
  - No divide and no multiply by non-constants: accumulate base and stride with adders.
- rd_addr holds its last value when rd_en=0. wr_addr is meaningful only when wr_en=1.
- Issue starts the cycle after start is sampled, with no bubble between butterflies absent hold.
- The delay lines are shift registers of length RD_LAT and BF_LAT and carry valid, address and the optional twiddle index.

Optional Feature:
- Macro: RADIX5_TWIDDLE_IDX_EN.
- Defined:
  - Adds output tw_idx, 5*ADDR_W, aligned with wr_addr.
  - Element m holds (m*off*5^s) mod NPTS, the twiddle exponent for the post-butterfly DIF rotation.
  - Element 0 is always 0.
  - Computed at issue time and carried through the delay line.
  - The last stage gives all zeros.
- Undefined: no port, no logic.

Test Plan:
- Reset then start at cycle T, hold=0:
  - rd_en at T+1..T+5, with stage-0 rd_addr {0,5,10,15,20}, {1,6,11,16,21}, …, {4,9,14,19,24}.
  - wr_en at T+14..T+18, same addresses.
- Same run, stage 1: rd_en at T+19..T+23 with {0,1,2,3,4} … {20,21,22,23,24}; last wr_en at T+36; done pulse at T+37; busy low at T+37.
- hold=1 during T+2..T+4: stage-0 issue becomes T+1, T+5..T+8; no address skipped or repeated; done at T+40.
- start pulsed again at T+10 while busy: ignored, sequence identical to the first scenario.
- rst_n low at T+16: all outputs 0 immediately; no wr_en after release; a new start runs the full first-scenario pattern.
- RADIX5_TWIDDLE_IDX_EN, stage 0, butterfly off=2: tw_idx {0,2,4,6,8} alongside wr_addr {2,7,12,17,22}; all stage-1 tw_idx zero.
